// File: rtl/hdmi_tx_pkg.sv
// rtl/hdmi_tx_pkg.sv - shared timing types, FSM states and colour-bar helpers
package hdmi_tx_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  typedef enum logic [1:0] {
    ST_SEEK   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_STREAM = 2'd2
  } raster_state_e;

  localparam int unsigned NUM_BARS = 8;

  // {R,G,B} component enables; each enabled component is driven all-ones
  localparam logic [2:0] RGB_WHITE   = 3'b111;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_BLACK   = 3'b000;

  function automatic int unsigned axis_total(axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // First h_cnt value belonging to bar idx
  function automatic int unsigned bar_threshold(int unsigned x_res, int unsigned idx);
    return (idx * x_res) / NUM_BARS;
  endfunction

  function automatic logic [2:0] bar_rgb(int unsigned idx);
    case (idx)
      0:       return RGB_WHITE;
      1:       return RGB_YELLOW;
      2:       return RGB_CYAN;
      3:       return RGB_GREEN;
      4:       return RGB_MAGENTA;
      5:       return RGB_RED;
      6:       return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_tx_raster_ctrl_if.sv
// rtl/hdmi_tx_raster_ctrl_if.sv - video stream bundle into the raster controller
interface hdmi_tx_raster_ctrl_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/hdmi_raster_cnt.sv
// rtl/hdmi_raster_cnt.sv - free-running h/v raster counters with region flags
module hdmi_raster_cnt
  import hdmi_tx_pkg::*;
#(
  parameter axis_timing_t H_TIM = '{active: 1920, fp: 88, sync: 44, bp: 148},
  parameter axis_timing_t V_TIM = '{active: 1080, fp: 4, sync: 5, bp: 36},
  parameter int HW = 12,
  parameter int VW = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_end_o
);

  localparam int unsigned H_TOTAL = axis_total(H_TIM);
  localparam int unsigned V_TOTAL = axis_total(V_TIM);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_TIM.active);
  localparam logic [HW-1:0] H_SS   = HW'(H_TIM.active + H_TIM.fp);
  localparam logic [HW-1:0] H_SE   = HW'(H_TIM.active + H_TIM.fp + H_TIM.sync);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_TIM.active);
  localparam logic [VW-1:0] V_SS   = VW'(V_TIM.active + V_TIM.fp);
  localparam logic [VW-1:0] V_SE   = VW'(V_TIM.active + V_TIM.fp + V_TIM.sync);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign active_o    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_o     = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
  assign vsync_o     = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
  assign frame_end_o = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

endmodule

// File: rtl/hdmi_tx_raster_ctrl.sv
// rtl/hdmi_tx_raster_ctrl.sv - raster owner locking a video stream to HDMI timing
// Fill is black unless HDMI_TX_RASTER_COLORBAR_EN selects 8 vertical colour bars.
module hdmi_tx_raster_ctrl
  import hdmi_tx_pkg::*;
#(
  parameter int unsigned X_RES    = 1920,
  parameter int unsigned Y_RES    = 1080,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter int unsigned PX_WIDTH = 10
) (
  input  logic                    px_clk_i,
  input  logic                    rst_i,
  hdmi_tx_raster_ctrl_if.slave    video_i,
  output logic [3*PX_WIDTH-1:0]   px_o,
  output logic                    de_o,
  output logic                    hsync_o,
  output logic                    vsync_o,
  output logic                    locked_o,
  output logic                    underrun_o,
  output logic                    frame_err_o
);

  localparam axis_timing_t H_TIM = '{active: X_RES, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam axis_timing_t V_TIM = '{active: Y_RES, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int HW  = $clog2(axis_total(H_TIM));
  localparam int VW  = $clog2(axis_total(V_TIM));
  localparam int PXW = 3 * PX_WIDTH;
  localparam logic [HW-1:0] X_LAST = HW'(X_RES - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, hsync, vsync, frame_end;

  hdmi_raster_cnt #(
    .H_TIM (H_TIM),
    .V_TIM (V_TIM),
    .HW    (HW),
    .VW    (VW)
  ) u_raster_cnt (
    .clk_i       (px_clk_i),
    .rst_i       (rst_i),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .active_o    (active),
    .hsync_o     (hsync),
    .vsync_o     (vsync),
    .frame_end_o (frame_end)
  );

  raster_state_e  state_q, state_d;
  logic [PXW-1:0] px_q, px_d, fill_px;
  logic           de_q, hsync_q, vsync_q, locked_q;
  logic           underrun_q, underrun_d, frame_err_q, frame_err_d;
  logic           ready;
  logic           is_line_end, is_origin;
  logic           unused_tdata;

  assign unused_tdata = ^video_i.tdata;
  assign is_line_end  = (h_cnt == X_LAST);
  assign is_origin    = (h_cnt == '0) && (v_cnt == '0);

`ifdef HDMI_TX_RASTER_COLORBAR_EN
  logic [2:0] bar_sel;

  always_comb begin
    bar_sel = bar_rgb(0);
    for (int unsigned i = 1; i < NUM_BARS; i++) begin
      if (32'(h_cnt) >= bar_threshold(X_RES, i)) bar_sel = bar_rgb(i);
    end
    fill_px = {{PX_WIDTH{bar_sel[2]}}, {PX_WIDTH{bar_sel[1]}}, {PX_WIDTH{bar_sel[0]}}};
  end
`else
  assign fill_px = '0;
`endif

  // The SOF beat is held (not accepted) in SEEK so it can be consumed at lock
  always_comb begin
    ready = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_SEEK:   ready = !(video_i.tvalid && video_i.tuser);
        ST_STREAM: ready = active;
        default:   ready = 1'b0;
      endcase
    end
  end

  assign video_i.tready = ready;

  always_comb begin
    state_d     = state_q;
    px_d        = active ? fill_px : '0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_SEEK: begin
        if (video_i.tvalid && video_i.tuser) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (frame_end) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (active) begin
          if (!video_i.tvalid) begin
            underrun_d = 1'b1;
            state_d    = ST_SEEK;
          end else begin
            px_d = video_i.tdata[PXW-1:0];
            if ((video_i.tlast != is_line_end) || (video_i.tuser && !is_origin)) begin
              frame_err_d = 1'b1;
              state_d     = ST_SEEK;
            end
          end
        end
      end
      default: state_d = ST_SEEK;
    endcase
  end

  always_ff @(posedge px_clk_i) begin
    if (rst_i) begin
      state_q     <= ST_SEEK;
      px_q        <= '0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      locked_q    <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      de_q        <= active;
      hsync_q     <= hsync;
      vsync_q     <= vsync;
      locked_q    <= (state_q == ST_STREAM);
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign px_o        = px_q;
  assign de_o        = de_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign locked_o    = locked_q;
  assign underrun_o  = underrun_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_hdmi_tx_raster_ctrl.sv
// tb/tb_hdmi_tx_raster_ctrl.sv - self-checking bench for hdmi_tx_raster_ctrl
// Reference model tracks raster position as cycles-since-reset modulo totals.
module tb_hdmi_tx_raster_ctrl;

  localparam int X  = 8;
  localparam int Y  = 4;
  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;
  localparam int M_SEEK = 0, M_ARMED = 1, M_STREAM = 2;

  logic clk = 1'b0;
  logic rst;
  logic [29:0] px;
  logic de, hs, vs, locked, und, ferr;

  always #5 clk = ~clk;

  hdmi_tx_raster_ctrl_if vif ();

  hdmi_tx_raster_ctrl #(
    .X_RES(8), .Y_RES(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .PX_WIDTH(10)
  ) dut (
    .px_clk_i    (clk),
    .rst_i       (rst),
    .video_i     (vif),
    .px_o        (px),
    .de_o        (de),
    .hsync_o     (hs),
    .vsync_o     (vs),
    .locked_o    (locked),
    .underrun_o  (und),
    .frame_err_o (ferr)
  );

  int checks = 0, failures = 0;
  int t, mode;
  int sx, sy;
  bit src_on;
  logic [31:0] sdata;
  int de_cnt, hs_cnt, vs_cnt, lk_cnt, ur_cnt, fe_cnt, rdy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] fill_of(int h);
`ifdef HDMI_TX_RASTER_COLORBAR_EN
    logic [2:0] c;
    case (h * 8 / X)
      0: c = 3'b111;  // white
      1: c = 3'b110;  // yellow
      2: c = 3'b011;  // cyan
      3: c = 3'b010;  // green
      4: c = 3'b101;  // magenta
      5: c = 3'b100;  // red
      6: c = 3'b001;  // blue
      default: c = 3'b000;
    endcase
    return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
`else
    return 30'd0;
`endif
  endfunction

  task automatic clr_cnt();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; lk_cnt = 0; ur_cnt = 0; fe_cnt = 0; rdy_cnt = 0;
  endtask

  task automatic tick(input bit r, input bit drop, input bit force_last, input bit force_user);
    int h, v, nmode;
    bit act, erdy, tv, tu, tl;
    logic [29:0] e_px;
    bit e_de, e_hs, e_vs, e_lk, e_ur, e_fe;
    h   = t % HT;
    v   = (t / HT) % VT;
    act = (h < X) && (v < Y);
    tv  = src_on && !drop;
    tu  = ((sx == 0) && (sy == 0)) || force_user;
    tl  = (sx == X - 1) || force_last;
    vif.tvalid = tv; vif.tuser = tu; vif.tlast = tl; vif.tdata = sdata;
    rst = r;
    #1;
    if (r)                   erdy = 0;
    else if (mode == M_SEEK) erdy = !(tv && tu);
    else if (mode == M_ARMED) erdy = 0;
    else                     erdy = act;
    check_eq("tready", {31'd0, vif.tready}, {31'd0, erdy});
    rdy_cnt += int'(vif.tready);

    nmode = mode; e_ur = 0; e_fe = 0;
    if (r) begin
      e_px = '0; e_de = 0; e_hs = 0; e_vs = 0; e_lk = 0; nmode = M_SEEK;
    end else begin
      e_de = act;
      e_hs = (h >= X + 2) && (h < X + 4);
      e_vs = (v == Y + 1);
      e_px = act ? fill_of(h) : 30'd0;
      e_lk = (mode == M_STREAM);
      if (mode == M_SEEK && tv && tu) nmode = M_ARMED;
      if (mode == M_ARMED && h == HT - 1 && v == VT - 1) nmode = M_STREAM;
      if (mode == M_STREAM && act) begin
        if (!tv) begin
          e_ur = 1; nmode = M_SEEK;
        end else begin
          e_px = sdata[29:0];
          if ((tl != (h == X - 1)) || (tu && (h != 0 || v != 0))) begin
            e_fe = 1; nmode = M_SEEK;
          end
        end
      end
    end

    @(posedge clk);
    #1;
    check_eq("px_o", {2'b0, px}, {2'b0, e_px});
    check_eq("de_o", {31'd0, de}, {31'd0, e_de});
    check_eq("hsync_o", {31'd0, hs}, {31'd0, e_hs});
    check_eq("vsync_o", {31'd0, vs}, {31'd0, e_vs});
    check_eq("locked_o", {31'd0, locked}, {31'd0, e_lk});
    check_eq("underrun_o", {31'd0, und}, {31'd0, e_ur});
    check_eq("frame_err_o", {31'd0, ferr}, {31'd0, e_fe});
    de_cnt += int'(de); hs_cnt += int'(hs); vs_cnt += int'(vs);
    lk_cnt += int'(locked); ur_cnt += int'(und); fe_cnt += int'(ferr);

    mode = nmode;
    t = r ? 0 : t + 1;
    if (tv && erdy) begin
      if (tl) begin
        sx = 0; sy = (sy + 1) % Y;
      end else begin
        sx = sx + 1;
      end
      sdata = $urandom;
    end
  endtask

  function automatic bit at(int h, int v);
    return ((t % HT) == h) && (((t / HT) % VT) == v);
  endfunction

  initial begin
    rst = 1'b1;
    vif.tvalid = 1'b0; vif.tdata = '0; vif.tuser = 1'b0; vif.tlast = 1'b0;
    t = 0; mode = M_SEEK; sx = 0; sy = 0; sdata = $urandom; src_on = 0;

    repeat (2) tick(1, 0, 0, 0);

    // idle raster, no source
    clr_cnt();
    repeat (FRAME) tick(0, 0, 0, 0);
    check_eq("idle_de_per_frame", de_cnt, 32);
    check_eq("idle_hsync_per_frame", hs_cnt, 14);
    check_eq("idle_vsync_per_frame", vs_cnt, 14);
    check_eq("idle_locked", lk_cnt, 0);

    // SOF offered mid-frame: armed for the rest, locks on the next frame
    src_on = 1; sx = 0; sy = 2;
    repeat (2 * FRAME) tick(0, 0, 0, 0);
    clr_cnt();
    repeat (FRAME) tick(0, 0, 0, 0);
    check_eq("stream_ready_per_frame", rdy_cnt, 32);
    check_eq("stream_locked_cycles", lk_cnt, FRAME);
    check_eq("stream_underruns", ur_cnt, 0);
    check_eq("stream_frame_errs", fe_cnt, 0);

    // tvalid gap at line 2 pixel 3
    clr_cnt();
    for (int i = 0; i < FRAME; i++) tick(0, at(3, 2), 0, 0);
    check_eq("gap_underrun_pulses", ur_cnt, 1);
    check_eq("gap_locked_cycles", lk_cnt, 32);
    clr_cnt();
    repeat (FRAME) tick(0, 0, 0, 0);
    check_eq("gap_relock_cycles", lk_cnt, FRAME);

    // early tlast on pixel 6 of line 0
    clr_cnt();
    for (int i = 0; i < FRAME; i++) tick(0, 0, at(6, 0), 0);
    check_eq("tlast_err_pulses", fe_cnt, 1);
    check_eq("tlast_locked_cycles", lk_cnt, 7);
    clr_cnt();
    repeat (FRAME) tick(0, 0, 0, 0);
    check_eq("tlast_relock_cycles", lk_cnt, FRAME);

    // reset pulse mid-stream
    repeat (20) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    check_eq("rst_locked_cleared", {31'd0, locked}, 32'd0);
    repeat (2 * FRAME) tick(0, 0, 0, 0);

    // randomized gaps, misplaced markers and occasional resets
    for (int i = 0; i < 8 * FRAME; i++) begin
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_tx_raster_ctrl.md
# hdmi_tx_raster_ctrl

- Single-clock controller in front of the HDMI TMDS encoder.
- Owns the raster: horizontal/vertical counters, hsync/vsync/de generation.
- Schedules an AXI4-Stream video source into that raster and locks frame start (tuser) to the first active pixel.
- Polices line length (tlast) and fills any lost or unlocked region with a defined fill pattern, so the HDMI link never loses timing.

## Interface
Parameters:
- X_RES, 1920, active pixels per line
- Y_RES, 1080, active lines per frame
- H_FP / H_SYNC / H_BP, 88 / 44 / 148, horizontal blanking segments (px)
- V_FP / V_SYNC / V_BP, 4 / 5 / 36, vertical blanking segments (lines)
- PX_WIDTH, 10, bits per colour component; 3*PX_WIDTH ≤ 32

Ports:
- px_clk_i  in  1  pixel clock; sole clock
- rst_i  in  1  synchronous, active-high reset
- video_i_tdata  in  32  pixel; [3*PX_WIDTH-1:0] = {R,G,B}, upper bits ignored
- video_i_tvalid  in  1  AXI4-Stream valid
- video_i_tready  out  1  AXI4-Stream ready
- video_i_tuser  in  1  start of frame, on the first pixel
- video_i_tlast  in  1  end of line, on pixel X_RES-1
- px_o  out  3*PX_WIDTH  pixel to the encoder
- de_o / hsync_o / vsync_o  out  1 each  data enable and syncs; syncs active-high
- locked_o  out  1  high while in STREAM
- underrun_o  out  1  one-cycle pulse: active cycle with no valid beat in STREAM
- frame_err_o  out  1  one-cycle pulse: tlast or tuser misplacement

## Operation
Raster:
- H_TOTAL = X_RES+H_FP+H_SYNC+H_BP; V_TOTAL analogous.
- h_cnt and v_cnt run freely from reset, regardless of stream state. Order: active, FP, sync, BP.
- Active region: h_cnt < X_RES and v_cnt < Y_RES.
- hsync: X_RES+H_FP ≤ h_cnt < X_RES+H_FP+H_SYNC. vsync: same form on v_cnt, asserted for whole lines.
- h_cnt wraps at H_TOTAL-1 and increments v_cnt; v_cnt wraps at V_TOTAL-1.

FSM (states SEEK, ARMED, STREAM):
- **SEEK:** tready = !(tvalid && tuser). Discard non-SOF beats. On tvalid && tuser, go to ARMED; the SOF beat is held, not accepted.
- **ARMED:** tready = 0. When h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, go to STREAM.
- **STREAM:** tready = 1 exactly in active cycles.
  - Active cycle with tvalid = 0: fill pixel, underrun_o pulse, go to SEEK.
  - Accepted beat with tlast ≠ (h_cnt == X_RES-1): frame_err_o pulse, go to SEEK; that pixel is still output.
  - Accepted beat with tuser = 1 when not at h_cnt = 0, v_cnt = 0: same error handling.
  - Simultaneous underrun and error impossible (error requires an accepted beat).
- Outside STREAM, active cycles output the fill pattern with de_o = 1.
- tready is combinational from state, counters and tvalid/tuser only; it never depends on tready itself.

## Timing
- All outputs registered. px_o/de_o/hsync_o/vsync_o reflect counter position of previous cycle, so an accepted beat appears on px_o exactly 1 cycle later, aligned with its de_o.
- Reset values:
  - counters 0, state SEEK
  - px_o 0, de_o/hsync_o/vsync_o 0, locked_o 0, pulses 0
- Reset mid-frame: everything returns to reset values next cycle. The upstream beat in flight is not accepted.
- Earliest lock after SOF arrival: end of the current frame. First streamed pixel appears on px_o 1 cycle after h_cnt = 0, v_cnt = 0.
- Return from STREAM to SEEK takes effect the cycle after the fault. Remaining active cycles of that frame are filled.

## Configuration
- HDMI_TX_RASTER_COLORBAR_EN undefined: fill pattern is black (all zero).
- Defined: fill pattern is 8 equal vertical bars by h_cnt: white, yellow, cyan, green, magenta, red, blue, black. Components are all-ones or zero.
- Ports and timing are identical in both builds.

## Structure
- hdmi_tx_pkg holds:
  - timing struct (active, FP, sync, BP per axis)
  - state enum
  - colour-bar constants
  - function returning bar index thresholds
- Sub-module hdmi_raster_cnt: counters plus combinational active/hsync/vsync/frame-end flags.
- This block instantiates hdmi_raster_cnt and adds the FSM and output registers.

## Test plan
Parameters for the bench: X_RES=8, Y_RES=4, all blanking segments=2/2/2 horizontal and 1/1/1 vertical (H_TOTAL 14, V_TOTAL 7).

1. Reset, no stream -> hsync_o high at h_cnt 10–11, vsync_o high on line 5, de_o 32 cycles per frame, px_o = 0, locked_o = 0.
2. Source always valid, correct tuser/tlast, SOF offered mid-frame -> ARMED until frame end. Pixel 0x00000001 (first) appears 1 cycle after h=0, v=0. locked_o = 1, tready high exactly 8 cycles per active line.
3. In STREAM, tvalid dropped at line 2 pixel 3 -> underrun_o one pulse. That pixel and rest of frame filled. Relock on next frame.
4. tlast asserted on pixel 6 -> frame_err_o pulse, SEEK; pixel 6 still output, pixel 7 filled.
5. rst_i pulsed one cycle during STREAM -> all outputs 0 next cycle, tready 0 in the reset cycle, counters restart at 0.
6. With HDMI_TX_RASTER_COLORBAR_EN, unlocked line -> px_o per pixel: white, yellow, cyan, green, magenta, red, blue, black.
